// File: rtl/disp_syncgen.sv
// Display timing generator: free-running H/V counters producing DSP_preDE, delayed active-low syncs, VBLANK, FRAME_START.
// Latency: DE/VBLANK/FRAME_START are 1 DCLK after the counter value; syncs are 1+SYNC_DLY DCLK after it.
// Backpressure: none, the timing runs freely; optional macro SYNCGEN_FRMCNT_EN adds the FRMCNT frame counter.
module disp_syncgen #(
    parameter int HPERIOD  = 800,
    parameter int HDISP    = 640,
    parameter int HFP      = 16,
    parameter int HSW      = 96,
    parameter int VPERIOD  = 525,
    parameter int VDISP    = 480,
    parameter int VFP      = 10,
    parameter int VSW      = 2,
    parameter int SYNC_DLY = 3
) (
    input  logic        DCLK,
    input  logic        DRST,
    input  logic        DISPON,
    output logic        DSP_preDE,
    output logic        DSP_HSYNC_X,
    output logic        DSP_VSYNC_X,
    output logic        VBLANK,
    output logic        FRAME_START
`ifdef SYNCGEN_FRMCNT_EN
    ,
    output logic [15:0] FRMCNT
`endif
);

    // Timing boundaries narrowed to the 11-bit counter width.
    localparam logic [10:0] H_LAST   = 11'(HPERIOD - 1);
    localparam logic [10:0] V_LAST   = 11'(VPERIOD - 1);
    localparam logic [10:0] H_ACT    = 11'(HDISP);
    localparam logic [10:0] V_ACT    = 11'(VDISP);
    localparam logic [10:0] HS_BEG   = 11'(HDISP + HFP);
    localparam logic [10:0] HS_END   = 11'(HDISP + HFP + HSW);
    localparam logic [10:0] VS_BEG   = 11'(VDISP + VFP);
    localparam logic [10:0] VS_END   = 11'(VDISP + VFP + VSW);

`ifndef SYNTHESIS
    // Catch timing parameters whose porches and sync do not fit in the period.
    initial begin
        if (HDISP + HFP + HSW > HPERIOD)
            $error("disp_syncgen: HDISP+HFP+HSW exceeds HPERIOD");
        if (VDISP + VFP + VSW > VPERIOD)
            $error("disp_syncgen: VDISP+VFP+VSW exceeds VPERIOD");
        if (SYNC_DLY < 0 || SYNC_DLY > 7)
            $error("disp_syncgen: SYNC_DLY outside 0..7");
    end
`endif

    logic [10:0]       hcnt_q, hcnt_d;
    logic [10:0]       vcnt_q, vcnt_d;
    logic              dispon_frame_q, dispon_frame_d;
    logic              de_q, de_d;
    logic              vblank_q, vblank_d;
    logic              fs_q, fs_d;
    logic [SYNC_DLY:0] hs_pipe_q, hs_pipe_d;
    logic [SYNC_DLY:0] vs_pipe_q, vs_pipe_d;
    logic              h_wrap;
    logic              v_wrap;
    logic              hs_raw;
    logic              vs_raw;
`ifdef SYNCGEN_FRMCNT_EN
    logic [15:0]       frmcnt_q, frmcnt_d;
`endif

    // Counter advance, frame-boundary DISPON capture and the decoded output values.
    always_comb begin
        h_wrap = (hcnt_q == H_LAST);
        v_wrap = (vcnt_q == V_LAST);
        hcnt_d = hcnt_q + 11'd1;
        vcnt_d = vcnt_q;
        if (h_wrap) begin
            hcnt_d = 11'd0;
            vcnt_d = v_wrap ? 11'd0 : vcnt_q + 11'd1;
        end
        // Only the last cycle of a frame samples DISPON so a frame is never partially shown.
        dispon_frame_d = (h_wrap && v_wrap) ? DISPON : dispon_frame_q;
        de_d     = (hcnt_q < H_ACT) && (vcnt_q < V_ACT) && dispon_frame_q;
        hs_raw   = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
        vs_raw   = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
        vblank_d = (vcnt_q >= V_ACT);
        fs_d     = (hcnt_q == 11'd0) && (vcnt_q == 11'd0);
    end

    // Sync delay lines: stage 0 is the registered raw sync, stage SYNC_DLY drives the pin.
    always_comb begin
        hs_pipe_d    = hs_pipe_q;
        vs_pipe_d    = vs_pipe_q;
        hs_pipe_d[0] = hs_raw;
        vs_pipe_d[0] = vs_raw;
        for (int i = 1; i <= SYNC_DLY; i++) begin
            hs_pipe_d[i] = hs_pipe_q[i-1];
            vs_pipe_d[i] = vs_pipe_q[i-1];
        end
    end

`ifdef SYNCGEN_FRMCNT_EN
    // Frame counter advances on the same edge that raises FRAME_START; wraps naturally at 16 bits.
    always_comb begin
        frmcnt_d = fs_d ? frmcnt_q + 16'd1 : frmcnt_q;
    end
`endif

    // State registers with synchronous active-high reset.
    always_ff @(posedge DCLK) begin
        if (DRST) begin
            hcnt_q         <= 11'd0;
            vcnt_q         <= 11'd0;
            dispon_frame_q <= 1'b0;
            de_q           <= 1'b0;
            vblank_q       <= 1'b1;
            fs_q           <= 1'b0;
            hs_pipe_q      <= '1;
            vs_pipe_q      <= '1;
`ifdef SYNCGEN_FRMCNT_EN
            frmcnt_q       <= 16'd0;
`endif
        end else begin
            hcnt_q         <= hcnt_d;
            vcnt_q         <= vcnt_d;
            dispon_frame_q <= dispon_frame_d;
            de_q           <= de_d;
            vblank_q       <= vblank_d;
            fs_q           <= fs_d;
            hs_pipe_q      <= hs_pipe_d;
            vs_pipe_q      <= vs_pipe_d;
`ifdef SYNCGEN_FRMCNT_EN
            frmcnt_q       <= frmcnt_d;
`endif
        end
    end

    assign DSP_preDE   = de_q;
    assign DSP_HSYNC_X = hs_pipe_q[SYNC_DLY];
    assign DSP_VSYNC_X = vs_pipe_q[SYNC_DLY];
    assign VBLANK      = vblank_q;
    assign FRAME_START = fs_q;
`ifdef SYNCGEN_FRMCNT_EN
    assign FRMCNT      = frmcnt_q;
`endif

endmodule
